// File: rtl/sched_pkg.sv
// Shared types and constants for the scheduled-assignment stage.
package sched_pkg;

  // FSM states: idle waiting for a request, or counting down to the commit edge
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } sched_state_e;

  // Request styles: sample now and commit later, or wait and then sample
  localparam logic MODE_INTRA   = 1'b0;
  localparam logic MODE_REGULAR = 1'b1;

  // Largest supported DELAY value
  localparam int SCHED_DELAY_MAX = 255;

  // Counter width needed to hold DELAY-1 (at least one bit)
  function automatic int sched_cnt_width(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/delay_down_counter.sv
// Loadable down counter that stops at zero and flags it.
module delay_down_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] count_r;

  // Load has priority; decrement only while enabled and not already at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/sched_assign_stage.sv
// Clocked stage producing intra-assignment / regular-delay style results
// of a|b, committed DELAY cycles after an accepted start, plus a free-running
// registered a|b reference.
module sched_assign_stage
  import sched_pkg::*;
#(
  parameter int DELAY = 25,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_cont
);

  localparam int CW = sched_cnt_width(DELAY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DELAY - 1);
  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};

  sched_state_e     state_r, state_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic [WIDTH-1:0] hold_r, hold_nxt_s;
  logic [WIDTH-1:0] y_r, y_nxt_s;
  logic [WIDTH-1:0] y_cont_r;
  logic [WIDTH-1:0] ab_s;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic             cnt_zero_s;

  assign ab_s = a | b;

  delay_down_counter #(
    .CW (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (CNT_LOAD),
    .en       (cnt_en_s),
    .zero     (cnt_zero_s)
  );

  // Next-state and next-output decode for the request FSM
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    hold_nxt_s  = hold_r;
    y_nxt_s     = y_r;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = WAIT;
          mode_nxt_s  = mode;
          busy_nxt_s  = 1'b1;
          cnt_load_s  = 1'b1;
          // Intra-assignment style captures the operands right now
          if (mode == MODE_INTRA) begin
            hold_nxt_s = ab_s;
          end else begin
            hold_nxt_s = hold_r;
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_zero_s) begin
          // Regular-delay style samples the operands at the commit edge
          if (mode_r == MODE_INTRA) begin
            y_nxt_s = hold_r;
          end else begin
            y_nxt_s = ab_s;
          end
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops any pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mode_r  <= MODE_INTRA;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hold_r  <= W_ZERO;
      y_r     <= W_ZERO;
    end else begin
      state_r <= state_nxt_s;
      mode_r  <= mode_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      hold_r  <= hold_nxt_s;
      y_r     <= y_nxt_s;
    end
  end

  // Every-cycle registered a|b reference, independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cont_r <= W_ZERO;
    end else begin
      y_cont_r <= ab_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign y      = y_r;
  assign y_cont = y_cont_r;

endmodule

// File: tb/tb_sched_assign_stage.sv
// Self-checking bench for sched_assign_stage: DELAY=25/WIDTH=1 and
// DELAY=1/WIDTH=4 instances compared against a timeline-based model.
module tb_sched_assign_stage;

  logic       clk;
  logic       rst_n;
  logic       start0, mode0, a0, b0;
  logic       busy0, done0, y0, ycont0;
  logic       start1, mode1;
  logic [3:0] a1, b1;
  logic       busy1, done1;
  logic [3:0] y1, ycont1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a request is a record of when it was accepted and when it commits
  bit         m_pend   [2];
  int         m_commit [2];
  bit         m_mode   [2];
  logic [3:0] m_val    [2];
  logic [3:0] m_y      [2];
  logic [3:0] m_yc     [2];
  logic       m_busy   [2];
  logic       m_done   [2];

  sched_assign_stage #(.DELAY(25), .WIDTH(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .y(y0), .y_cont(ycont0)
  );

  sched_assign_stage #(.DELAY(1), .WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .y(y1), .y_cont(ycont1)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dly(input int i);
    return (i == 0) ? 25 : 1;
  endfunction

  task automatic model_clear(input int i);
    m_pend[i] = 1'b0; m_commit[i] = 0; m_mode[i] = 1'b0; m_val[i] = 4'h0;
    m_y[i] = 4'h0; m_yc[i] = 4'h0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
  endtask

  // One rising edge of the model, given the inputs present before the edge
  task automatic model_edge(input int i, input logic st, input logic md, input logic [3:0] ab);
    if (!rst_n) begin
      model_clear(i);
    end else begin
      m_yc[i]   = ab;
      m_done[i] = 1'b0;
      if (m_pend[i]) begin
        if (cyc == m_commit[i]) begin
          m_y[i]    = m_mode[i] ? ab : m_val[i];
          m_done[i] = 1'b1;
          m_busy[i] = 1'b0;
          m_pend[i] = 1'b0;
        end
      end else if (st) begin
        m_pend[i]   = 1'b1;
        m_commit[i] = cyc + dly(i);
        m_mode[i]   = md;
        m_val[i]    = ab;
        m_busy[i]   = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("busy0",  {3'b000, busy0},  {3'b000, m_busy[0]});
    chk("done0",  {3'b000, done0},  {3'b000, m_done[0]});
    chk("y0",     {3'b000, y0},     m_y[0]);
    chk("ycont0", {3'b000, ycont0}, m_yc[0]);
    chk("busy1",  {3'b000, busy1},  {3'b000, m_busy[1]});
    chk("done1",  {3'b000, done1},  {3'b000, m_done[1]});
    chk("y1",     y1,               m_y[1]);
    chk("ycont1", ycont1,           m_yc[1]);
  endtask

  task automatic tick();
    cyc++;
    model_edge(0, start0, mode0, {3'b000, a0 | b0});
    model_edge(1, start1, mode1, a1 | b1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; mode0 = 1'b0; a0 = 1'b0; b0 = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    model_clear(0);
    model_clear(1);

    // Reset state
    repeat (2) tick();
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // Test 1 + 3: mode 0, a falls after edge 10
    a0 = 1'b1; b0 = 1'b0; mode0 = 1'b0; start0 = 1'b1;
    tick();                                   // edge 1
    start0 = 1'b0;
    chk("t1_busy_e1", {3'b000, busy0}, 4'h1);
    repeat (9) tick();                        // edges 2..10
    chk("t3_ycont_e10", {3'b000, ycont0}, 4'h1);
    a0 = 1'b0;
    tick();                                   // edge 11
    chk("t3_ycont_e11", {3'b000, ycont0}, 4'h0);
    repeat (14) tick();                       // edges 12..25
    chk("t1_busy_e25", {3'b000, busy0}, 4'h1);
    tick();                                   // edge 26
    chk("t1_y_e26", {3'b000, y0}, 4'h1);
    chk("t1_done_e26", {3'b000, done0}, 4'h1);
    tick();
    chk("t1_done_e27", {3'b000, done0}, 4'h0);
    repeat (3) tick();

    // Test 2: mode 1, same stimulus, result sampled after a fell
    a0 = 1'b1; b0 = 1'b0; mode0 = 1'b1; start0 = 1'b1;
    tick();                                   // edge 1
    start0 = 1'b0; mode0 = 1'b0;
    repeat (9) tick();
    a0 = 1'b0;
    repeat (16) tick();                       // edges 11..26
    chk("t2_y_e26", {3'b000, y0}, 4'h0);
    chk("t2_done_e26", {3'b000, done0}, 4'h1);
    repeat (3) tick();

    // Test 4: pulse during WAIT is ignored, pulse in the done cycle is taken
    a0 = 1'b1; b0 = 1'b0; mode0 = 1'b0; start0 = 1'b1;
    tick();                                   // edge 1
    start0 = 1'b0;
    repeat (3) tick();                        // edges 2..4
    start0 = 1'b1;
    tick();                                   // edge 5
    start0 = 1'b0;
    repeat (21) tick();                       // edges 6..26
    chk("t4_done_e26", {3'b000, done0}, 4'h1);
    a0 = 1'b0; b0 = 1'b1; start0 = 1'b1;
    tick();                                   // edge 27 accept
    start0 = 1'b0; a0 = 1'b0; b0 = 1'b0;
    chk("t4_busy_e27", {3'b000, busy0}, 4'h1);
    repeat (24) tick();                       // edges 28..51
    chk("t4_nodone_e51", {3'b000, done0}, 4'h0);
    tick();                                   // edge 52
    chk("t4_done_e52", {3'b000, done0}, 4'h1);
    chk("t4_y_e52", {3'b000, y0}, 4'h1);
    repeat (3) tick();

    // Test 5: reset mid-request, then a fresh request
    a0 = 1'b1; b0 = 1'b0; mode0 = 1'b0; start0 = 1'b1;
    tick();                                   // edge 1
    start0 = 1'b0;
    repeat (11) tick();                       // edges 2..12
    rst_n = 1'b0;
    #1;
    model_clear(0);
    model_clear(1);
    compare_all();
    chk("t5_y_rst", {3'b000, y0}, 4'h0);
    chk("t5_busy_rst", {3'b000, busy0}, 4'h0);
    repeat (2) tick();                        // edges 13..14
    rst_n = 1'b1;
    repeat (30) tick();
    chk("t5_y_after", {3'b000, y0}, 4'h0);
    a0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0; a0 = 1'b0;
    repeat (25) tick();
    chk("t5_y_fresh", {3'b000, y0}, 4'h1);
    chk("t5_done_fresh", {3'b000, done0}, 4'h1);
    repeat (2) tick();

    // Test 6: DELAY=1, WIDTH=4
    a1 = 4'b1010; b1 = 4'b0101; mode1 = 1'b0; start1 = 1'b1;
    tick();                                   // edge k
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    chk("t6_busy_k", {3'b000, busy1}, 4'h1);
    tick();                                   // edge k+1
    chk("t6_y_k1", y1, 4'b1111);
    chk("t6_done_k1", {3'b000, done1}, 4'h1);
    tick();
    chk("t6_done_k2", {3'b000, done1}, 4'h0);

    // Randomized traffic on both instances
    for (int n = 0; n < 800; n++) begin
      start0 = ($urandom_range(0, 5) == 0);
      mode0  = 1'($urandom);
      a0     = 1'($urandom);
      b0     = 1'($urandom);
      start1 = ($urandom_range(0, 2) == 0);
      mode1  = 1'($urandom);
      a1     = 4'($urandom);
      b1     = 4'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sched_assign_stage.md
# sched_assign_stage

Synthesizable, clocked stage that produces the scheduled-assignment results the variable-behaviour demos exercise with `#` delays. On a start pulse it either samples `a|b` immediately and commits it `DELAY` cycles later (intra-assignment style), or waits `DELAY` cycles and then samples and commits (regular-delay style). A free-running registered `a|b` output provides the every-cycle reference.

## Interface
- `DELAY`, default 25: cycles between accepted start and commit; legal range 1..255.
- `WIDTH`, default 1: width of `a`, `b`, `y`, `y_cont`.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `mode`  in  1  0 = sample-then-wait (intra-assignment), 1 = wait-then-sample (regular delay); sampled with `start`.
- `a`  in  WIDTH  operand.
- `b`  in  WIDTH  operand.
- `busy`  out  1  high while a request is in flight.
- `done`  out  1  one-cycle pulse after commit.
- `y`  out  WIDTH  committed scheduled result.
- `y_cont`  out  WIDTH  `a|b` registered every cycle.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `y`=0, `y_cont`=0, hold register 0, counter 0.
- `y_cont` <= `a|b` on every rising edge; independent of the FSM.
- IDLE: on `start`=1, latch `mode` into `mode_q` and load counter with `DELAY-1`. If `mode`=0, capture `a|b` into hold. Go to WAIT and set `busy`=1.
- IDLE with `start`=0: remain; `done` cleared.
- WAIT: counter decrements each cycle. When counter==0:
  - `y` <= hold if `mode_q`=0, else current `a|b`.
  - `done` <= 1; `busy` <= 0; return to IDLE.
- Changes on `a`/`b` during WAIT never affect `y` in mode 0. In mode 1, only the values present at the commit edge matter.
- `start` while `busy`=1 is ignored, with no queueing.
- `start` in the cycle `done` is high is accepted, because the FSM is already IDLE.
- `mode` changes during WAIT have no effect.
- Reset mid-operation: immediate return to reset values. No `done` and no commit; the pending request is lost.
- Width rule: `y`, hold and `y_cont` are exactly `WIDTH` bits, bitwise OR, no extension. The counter is `$clog2(DELAY)` bits, minimum 1.

## Timing
- `start` sampled at edge k:
  - `busy` high from edge k through edge k+DELAY.
  - `y` updates at edge k+DELAY.
  - `done` high for one cycle following edge k+DELAY.
- Mode 0 sample point: edge k. Mode 1 sample point: edge k+DELAY.
- DELAY=1: commit at edge k+1.
- Back-to-back requests: at most one per DELAY+1... The earliest next accept is edge k+DELAY+1, giving throughput of 1 request per DELAY+1 cycles.
- `y_cont` latency: 1 cycle.
- `y` holds its value between commits.

## Structure
- Shared package `sched_pkg`:
  - State enum `{IDLE, WAIT}`.
  - Mode constants `MODE_INTRA=1'b0` and `MODE_REGULAR=1'b1`.
  - Delay-limit constant `SCHED_DELAY_MAX=255`.
- One sub-module, `delay_down_counter`: loadable down counter with `load`, `load_val`, `en`, and a `zero` flag. The FSM and output registers stay in the top.

## Test plan
1. DELAY=25, WIDTH=1. a=1, b=0, `start` with mode 0 at edge 1; a→0 at edge 10. Required: y=1 at edge 26; done pulse one cycle after edge 26; busy high edges 1–26.
2. Same stimulus with mode 1. Required: y=0 at edge 26 (sampled after a fell).
3. `y_cont` with the same a/b sequence. Required: y_cont=1 through edge 10, y_cont=0 from edge 11.
4. `start` pulsed again at edge 5 during WAIT, then re-pulsed in the done cycle. Required: the edge-5 pulse is ignored (single done at edge 26+); the re-pulse is accepted and commits DELAY cycles later.
5. rst_n driven low at edge 12 mid-request, released at edge 14. Required: y=0, busy=0, done never pulses; a fresh start after release behaves as in test 1.
6. DELAY=1, WIDTH=4, a=4'b1010, b=4'b0101, mode 0 at edge k. Required: y=4'b1111 at edge k+1; done the following cycle.
